program_counter_ras: RTL

Parametrised program counter unit for the fetch stage that replaces the plain enable-gated PC register. It selects the next fetch address from sequential increment, jump, return prediction, taken branch and exception sources. Redirects raised while fetch is stalled are held in a pending register until they can be applied. An N-entry return-address stack (RAS) predicts `jr $31` targets.

---
 rtl/program_counter_ras_if.sv | 33 +++
 rtl/program_counter_ras.sv | 74 +++++++
 2 files changed

// File: rtl/program_counter_ras_if.sv
// program_counter_ras_if: fetch-side redirect requests and PC/RAS status
// between the fetch controller and the program counter unit.
interface program_counter_ras_if #(
    parameter int PC_W = 32
);
    logic            PCen;
    logic            exc;
    logic [PC_W-1:0] excvector;
    logic            brtaken;
    logic [PC_W-1:0] brtarget;
    logic            jump;
    logic [PC_W-1:0] jtarget;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] retaddr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic            pending;
    logic [PC_W-1:0] ras_pred;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_uflow;

    modport master (
        output PCen, exc, excvector, brtaken, brtarget, jump, jtarget, call, ret, retaddr,
        input  pc, npc, pending, ras_pred, ras_empty, ras_full, ras_uflow
    );

    modport slave (
        input  PCen, exc, excvector, brtaken, brtarget, jump, jtarget, call, ret, retaddr,
        output pc, npc, pending, ras_pred, ras_empty, ras_full, ras_uflow
    );
endinterface

// File: rtl/program_counter_ras.sv
// program_counter_ras: fetch PC with prioritised redirects, a pending redirect
// held across stalls, and a circular return-address stack for jr $31.
module program_counter_ras #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input logic CLK,
    input logic RST,
    program_counter_ras_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);

    logic [PC_W-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]   ptr, top;
    logic [PW:0]     cnt;
    logic [PC_W-1:0] pc_q, pend_tgt, new_tgt, sel_tgt, pred;
    logic [2:0]      pend_pri, new_pri, sel_pri;
    logic            ras_has, do_ret, do_push, uflow_q;

    // ptr is the next write slot; the top of stack sits just below it
    assign top     = ptr - PW'(1);
    assign ras_has = cnt != '0;
    assign pred    = ras_has ? stack[top] : '0;

    always_comb begin
        do_ret  = bus.ret && !bus.exc && ras_has;
        do_push = bus.call && bus.jump && !bus.exc;
        new_pri = bus.exc ? 3'd4 : bus.brtaken ? 3'd3 : do_ret ? 3'd2 : bus.jump ? 3'd1 : 3'd0;
        new_tgt = bus.exc ? bus.excvector : bus.brtaken ? bus.brtarget :
                  do_ret ? pred : bus.jump ? bus.jtarget : '0;
        sel_pri = (new_pri != '0 && new_pri >= pend_pri) ? new_pri : pend_pri;
        sel_tgt = (new_pri != '0 && new_pri >= pend_pri) ? new_tgt : pend_tgt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= RESET_PC;
            pend_pri <= '0;
            pend_tgt <= '0;
            ptr      <= '0;
            cnt      <= '0;
            uflow_q  <= 1'b0;
        end else begin
            pc_q     <= bus.PCen ? (sel_pri != '0 ? sel_tgt : bus.npc) : pc_q;
            pend_pri <= bus.PCen ? '0 : sel_pri;
            pend_tgt <= bus.PCen ? '0 : sel_tgt;
            uflow_q  <= bus.ret && !bus.exc && !ras_has;
            if (bus.exc) begin
                ptr <= '0;
                cnt <= '0;
            end else if (do_ret && do_push) begin
                stack[top] <= bus.retaddr;
            end else if (do_ret) begin
                ptr <= top;
                cnt <= cnt - 1'b1;
            end else if (do_push) begin
                stack[ptr] <= bus.retaddr;
                ptr        <= ptr + PW'(1);
                cnt        <= cnt == CNT_FULL ? cnt : cnt + 1'b1;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.npc       = pc_q + PC_W'(INSTR_BYTES);
    assign bus.pending   = pend_pri != '0;
    assign bus.ras_pred  = pred;
    assign bus.ras_empty = !ras_has;
    assign bus.ras_full  = cnt == CNT_FULL;
    assign bus.ras_uflow = uflow_q;
endmodule
